// File: rtl/fsm_proc_pkg.sv
// Shared encodings for the FSM processor: main-FSM state codes, step controller states, default widths.
package fsm_proc_pkg;

  localparam int CNT_W_DEF    = 4;
  localparam int STATE_W_DEF  = 3;
  localparam int OP_W_DEF     = 2;
  localparam int DEF_TERM_DEF = 3;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_CMP   = 3'd4;

  typedef enum logic [1:0] {
    CS_IDLE = 2'd0,
    CS_RUN  = 2'd1,
    CS_DONE = 2'd2
  } ctl_t;

endpackage

// File: rtl/term_regfile.sv
// Per-opcode terminal count registers; write lands at the clock edge, read is combinational.
// No backpressure: a write is always accepted, and a same-cycle read of that index returns the old value.
module term_regfile
  import fsm_proc_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int OP_W     = OP_W_DEF,
  parameter int DEF_TERM = DEF_TERM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [OP_W-1:0]  wr_idx,
  input  logic [CNT_W-1:0] wr_dat,
  input  logic [OP_W-1:0]  rd_idx,
  output logic [CNT_W-1:0] rd_dat
);

  logic [CNT_W-1:0] regs [2**OP_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**OP_W; i++) regs[i] <= CNT_W'(DEF_TERM);
    end else if (wr_en) begin
      regs[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = regs[rd_idx];

endmodule

// File: rtl/step_counter.sv
// Micro-step counter beside the main FSM: runs from ST_EXEC until it reaches term[op_q], or until a fetch or cmp hit aborts it.
// done appears 1 cycle after the terminal step and is held until done_ack; steps outside RUN are dropped.
module step_counter
  import fsm_proc_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STATE_W  = STATE_W_DEF,
  parameter int OP_W     = OP_W_DEF,
  parameter int DEF_TERM = DEF_TERM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  input  logic [OP_W-1:0]    opcode,
  input  logic               cmp,
  input  logic               step,
  input  logic               cfg_we,
  input  logic [OP_W-1:0]    cfg_op,
  input  logic [CNT_W-1:0]   cfg_term,
  input  logic               done_ack,
  output logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic               cnt_rst
);

  ctl_t             ctl;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] term_cur;
  logic             abort;
  logic             early;
  logic             at_term;

  term_regfile #(
    .CNT_W   (CNT_W),
    .OP_W    (OP_W),
    .DEF_TERM(DEF_TERM)
  ) u_term (
    .clk   (clk),
    .rst   (rst),
    .wr_en (cfg_we),
    .wr_idx(cfg_op),
    .wr_dat(cfg_term),
    .rd_idx(op_q),
    .rd_dat(term_cur)
  );

  // >= rather than == so a term lowered mid-run still terminates, and count can never wrap.
  assign abort   = (state == STATE_W'(ST_FETCH));
  assign early   = (state == STATE_W'(ST_CMP)) && cmp;
  assign at_term = step && (count >= term_cur);
  assign cnt_rst = (ctl == CS_RUN) && (abort || early || at_term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl   <= CS_IDLE;
      count <= '0;
      op_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (ctl)
        CS_IDLE: begin
          count <= '0;
          if (state == STATE_W'(ST_EXEC)) begin
            ctl  <= CS_RUN;
            op_q <= opcode;
            busy <= 1'b1;
          end
        end
        CS_RUN: begin
          if (abort || early) begin
            ctl   <= CS_IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (at_term) begin
            ctl   <= CS_DONE;
            count <= '0;
            done  <= 1'b1;
          end else if (step) begin
            count <= count + CNT_W'(1);
          end
        end
        CS_DONE: begin
          count <= '0;
          if (done_ack) begin
            ctl  <= CS_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
          end
        end
        default: begin
          ctl   <= CS_IDLE;
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
